// File: rtl/mux_pkg.sv
// Shared types and constants for the arbitrated writeback mux.
package mux_pkg;

  localparam int WORD_W = 16;
  localparam int MIN_N  = 2;
  localparam int MAX_N  = 16;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_t;

  // Next round-robin start position after index idx has been served.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority search: first set request at or above ptr,
// wrapping from N-1 back to 0.
module rr_priority_picker #(
  parameter  int N     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] idx,
  output logic             any_grant
);

  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any_grant && req[j]) begin
        grant[j]  = 1'b1;
        idx       = SEL_W'(j);
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux_n_to_1.sv
// N-channel arbitrated mux with a one-entry registered output stage.
// Fixed-select or round-robin grant; valid/ready on every channel and the output.
module rr_arb_mux_n_to_1
  import mux_pkg::*;
#(
  parameter  int WIDTH = WORD_W,
  parameter  int N     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [N*WIDTH-1:0] In_Data,
  input  logic [N-1:0]       In_Valid,
  output logic [N-1:0]       In_Ready,
  input  logic               Mode,
  input  logic [SEL_W-1:0]   Selection,
  output logic [WIDTH-1:0]   Out_Data,
  output logic [SEL_W-1:0]   Out_Source,
  output logic               Out_Valid,
  input  logic               Out_Ready
);

  mux_mode_t        mode_e;
  logic [SEL_W-1:0] rr_ptr;
  logic [N-1:0]     rr_grant;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;
  logic [N-1:0]     fix_grant;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_any;
  logic             can_accept;
  logic             xfer;
  logic [SEL_W-1:0] ptr_next;
  logic [WIDTH-1:0] sel_data;

  assign mode_e = mux_mode_t'(Mode);

  rr_priority_picker #(.N(N)) u_picker (
    .req       (In_Valid),
    .ptr       (rr_ptr),
    .grant     (rr_grant),
    .idx       (rr_idx),
    .any_grant (rr_any)
  );

  // Out-of-range selections (non power-of-two N) simply grant nothing.
  always_comb begin
    fix_grant = '0;
    if (int'(Selection) < N)
      fix_grant[Selection] = In_Valid[Selection];
  end

  always_comb begin
    grant     = fix_grant;
    grant_idx = Selection;
    grant_any = |fix_grant;
    if (mode_e == MODE_RR) begin
      grant     = rr_grant;
      grant_idx = rr_idx;
      grant_any = rr_any;
    end
  end

  // Out_Ready reaches In_Ready combinationally so a draining slot refills in the same cycle.
  assign can_accept = !Out_Valid || Out_Ready;
  assign xfer       = grant_any && can_accept && !Reset;
  assign In_Ready   = grant & {N{xfer}};

  assign ptr_next = SEL_W'(wrap_inc(int'(grant_idx), N));
  assign sel_data = In_Data[grant_idx*WIDTH +: WIDTH];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Out_Valid  <= 1'b0;
      Out_Data   <= '0;
      Out_Source <= '0;
      rr_ptr     <= '0;
    end else begin
      if (xfer) begin
        Out_Valid  <= 1'b1;
        Out_Data   <= sel_data;
        Out_Source <= grant_idx;
        if (mode_e == MODE_RR)
          rr_ptr <= ptr_next;
      end else if (Out_Ready) begin
        Out_Valid <= 1'b0;
      end
    end
  end

  a_ready_onehot0 : assert property (@(posedge Clock) disable iff (Reset) $onehot0(In_Ready));

endmodule

// File: tb/tb_rr_arb_mux_n_to_1.sv
// Scoreboard bench for rr_arb_mux_n_to_1 (N=8 and N=5) plus the priority picker alone.
module tb_rr_arb_mux_n_to_1;
  import mux_pkg::*;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*W-1:0]  in_data = '0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic            mode = 1'b0;
  logic [SW-1:0]   sel = '0;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_source;
  logic            out_valid;
  logic            out_ready = 1'b1;

  logic [5*W-1:0]  i5_in_data = '0;
  logic [4:0]      i5_in_valid = '0;
  logic [4:0]      i5_in_ready;
  logic            i5_mode = 1'b0;
  logic [2:0]      i5_sel = '0;
  logic [W-1:0]    i5_out_data;
  logic [2:0]      i5_out_source;
  logic            i5_out_valid;
  logic            i5_out_ready = 1'b1;

  logic [7:0]      pk_req = '0;
  logic [2:0]      pk_ptr = '0;
  logic [7:0]      pk_grant;
  logic [2:0]      pk_idx;
  logic            pk_any;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] src;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_arb_mux_n_to_1 #(.WIDTH(W), .N(N)) dut (
    .Clock(clk), .Reset(rst), .In_Data(in_data), .In_Valid(in_valid), .In_Ready(in_ready),
    .Mode(mode), .Selection(sel), .Out_Data(out_data), .Out_Source(out_source),
    .Out_Valid(out_valid), .Out_Ready(out_ready)
  );

  rr_arb_mux_n_to_1 #(.WIDTH(W), .N(5)) dut5 (
    .Clock(clk), .Reset(rst), .In_Data(i5_in_data), .In_Valid(i5_in_valid), .In_Ready(i5_in_ready),
    .Mode(i5_mode), .Selection(i5_sel), .Out_Data(i5_out_data), .Out_Source(i5_out_source),
    .Out_Valid(i5_out_valid), .Out_Ready(i5_out_ready)
  );

  rr_priority_picker #(.N(8)) u_pick (
    .req(pk_req), .ptr(pk_ptr), .grant(pk_grant), .idx(pk_idx), .any_grant(pk_any)
  );

  // Every word leaving the output register must match the oldest expected word.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: got data=%h src=%0d with no word expected", out_data, out_source);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.data || out_source !== e.src) begin
          errors++;
          $display("FAIL sb_word: got data=%h src=%0d, want data=%h src=%0d", out_data, out_source, e.data, e.src);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  task automatic test_reset();
    in_valid = 8'hFF; out_ready = 1'b1; mode = 1'b0; sel = '0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rst_data: got %h want 0000", out_data); end
    checks++; if (out_source !== 3'd0) begin errors++; $display("FAIL rst_source: got %0d want 0", out_source); end
    checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL rst_in_ready: got %h want 00", in_ready); end
  endtask

  task automatic test_fixed();
    tick();
    rst = 1'b0; mode = 1'b0; sel = 3'd2; in_valid = 8'h04; set_ch(2, 16'h0003); out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 8'h04) begin errors++; $display("FAIL fixed_ready: got %h want 04", in_ready); end
    sb.push_back('{16'h0003, 3'd2});
    tick();
    in_valid = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fixed_latency: got valid %b want 1", out_valid); end
    checks++; if (out_data !== 16'h0003) begin errors++; $display("FAIL fixed_data: got %h want 0003", out_data); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fixed_drain: got valid %b want 0", out_valid); end
  endtask

  task automatic test_rr_sweep();
    logic [N-1:0] eg;
    tick();
    mode = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_ch(i, 16'(i + 1));
    in_valid = 8'hFF;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      eg = '0;
      eg[c % N] = 1'b1;
      checks++; if (in_ready !== eg) begin errors++; $display("FAIL rr_sweep_grant c=%0d: got %h want %h", c, in_ready, eg); end
      if (c > 0) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_sweep_rate c=%0d: got valid %b want 1", c, out_valid); end
      end
      sb.push_back('{16'((c % N) + 1), SW'(c % N)});
      tick();
    end
    in_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_rr_wrap();
    logic [N-1:0] eg [3];
    eg[0] = 8'h80; eg[1] = 8'h01; eg[2] = 8'h80;
    tick();
    mode = 1'b1; out_ready = 1'b1; in_valid = 8'h81;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (in_ready !== eg[k]) begin errors++; $display("FAIL rr_wrap_grant k=%0d: got %h want %h", k, in_ready, eg[k]); end
      if (eg[k] == 8'h80) sb.push_back('{16'h0008, 3'd7});
      else                sb.push_back('{16'h0001, 3'd0});
      tick();
    end
    in_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    tick();
    mode = 1'b0; sel = 3'd0; set_ch(0, 16'h00AA); in_valid = 8'h01; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 8'h01) begin errors++; $display("FAIL bp_load: got %h want 01", in_ready); end
    sb.push_back('{16'h00AA, 3'd0});
    tick();
    sel = 3'd1; set_ch(1, 16'h00BB); in_valid = 8'h02;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL bp_stall_ready k=%0d: got %h want 00", k, in_ready); end
      checks++; if (out_data !== 16'h00AA || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_stall_hold k=%0d: got %h/%b want 00AA/1", k, out_data, out_valid);
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 8'h02) begin errors++; $display("FAIL bp_release: got %h want 02", in_ready); end
    sb.push_back('{16'h00BB, 3'd1});
    tick();
    in_valid = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h00BB) begin
      errors++; $display("FAIL bp_replace: got %h/%b want 00BB/1", out_data, out_valid);
    end
    tick();
  endtask

  task automatic test_async_reset();
    mode = 1'b1; set_ch(3, 16'h0044); set_ch(1, 16'h0022); set_ch(5, 16'h0066);
    in_valid = 8'h08; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 8'h08) begin errors++; $display("FAIL ar_load: got %h want 08", in_ready); end
    sb.push_back('{16'h0044, 3'd3});
    tick();
    in_valid = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_held: got %b want 1", out_valid); end
    #2;
    rst = 1'b1; in_valid = 8'h22; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin
      errors++; $display("FAIL ar_immediate: got %h/%b want 0000/0", out_data, out_valid);
    end
    checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL ar_ready_forced: got %h want 00", in_ready); end
    sb.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 8'h02) begin errors++; $display("FAIL ar_ptr_cleared: got %h want 02", in_ready); end
    sb.push_back('{16'h0022, 3'd1});
    tick();
    in_valid = '0;
    @(negedge clk);
    tick();
  endtask

  task automatic test_n5_bad_sel();
    for (int i = 0; i < 5; i++) i5_in_data[i*W +: W] = 16'(16'h0050 + i);
    i5_mode = 1'b0; i5_sel = 3'd6; i5_in_valid = 5'h1F; i5_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (i5_in_ready !== 5'h00 || i5_out_valid !== 1'b0) begin
        errors++; $display("FAIL n5_bad_sel k=%0d: got ready %h valid %b want 00/0", k, i5_in_ready, i5_out_valid);
      end
      tick();
    end
    i5_sel = 3'd4;
    @(negedge clk);
    checks++; if (i5_in_ready !== 5'h10) begin errors++; $display("FAIL n5_sel4_ready: got %h want 10", i5_in_ready); end
    tick();
    i5_in_valid = '0;
    @(negedge clk);
    checks++; if (i5_out_valid !== 1'b1 || i5_out_source !== 3'd4 || i5_out_data !== 16'h0054) begin
      errors++; $display("FAIL n5_sel4_word: got %b/%0d/%h want 1/4/0054", i5_out_valid, i5_out_source, i5_out_data);
    end
    tick();
  endtask

  typedef struct packed {
    logic [7:0] req;
    logic [2:0] ptr;
    logic [7:0] grant;
    logic [2:0] idx;
    logic       any;
  } pick_case_t;

  task automatic test_picker();
    pick_case_t tc [7];
    tc[0] = '{8'h00, 3'd3, 8'h00, 3'd0, 1'b0};
    tc[1] = '{8'h81, 3'd1, 8'h80, 3'd7, 1'b1};
    tc[2] = '{8'h81, 3'd0, 8'h01, 3'd0, 1'b1};
    tc[3] = '{8'h10, 3'd5, 8'h10, 3'd4, 1'b1};
    tc[4] = '{8'hFF, 3'd7, 8'h80, 3'd7, 1'b1};
    tc[5] = '{8'h06, 3'd3, 8'h02, 3'd1, 1'b1};
    tc[6] = '{8'h24, 3'd6, 8'h04, 3'd2, 1'b1};
    for (int i = 0; i < 7; i++) begin
      pk_req = tc[i].req; pk_ptr = tc[i].ptr;
      #1;
      checks++;
      if (pk_grant !== tc[i].grant || pk_any !== tc[i].any || (tc[i].any && pk_idx !== tc[i].idx)) begin
        errors++;
        $display("FAIL picker_%0d: got g=%h i=%0d a=%b want g=%h i=%0d a=%b",
                 i, pk_grant, pk_idx, pk_any, tc[i].grant, tc[i].idx, tc[i].any);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fixed();
    test_rr_sweep();
    test_rr_wrap();
    test_backpressure();
    test_async_reset();
    test_n5_bad_sel();
    test_picker();
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d words outstanding want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux_n_to_1.md
Name: rr_arb_mux_n_to_1

Overview:
Parametrised successor to the fixed 8-to-1 16-bit datapath mux. It is an N-channel arbitrated mux with a one-entry registered output stage and valid/ready handshakes on every input and on the output. It supports two modes: fixed selection (legacy behaviour, registered) and round-robin arbitration. It sits between the register-file/ALU result sources and the writeback bus, where several producers now compete for one bus.

Parameters:
WIDTH, 16, data width of each channel and of the output.
N, 8, number of input channels; legal range 2..16.
SEL_W, $clog2(N), width of the select/source index; derived, never overridden.

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
In_Data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH]
In_Valid  input  N  per-channel valid
In_Ready  output  N  per-channel ready, one-hot or zero
Mode  input  1  0 = fixed (use Selection), 1 = round-robin
Selection  input  SEL_W  channel index used in fixed mode
Out_Data  output  WIDTH  registered output data
Out_Source  output  SEL_W  index of the channel that produced Out_Data
Out_Valid  output  1  output holds a word
Out_Ready  input  1  downstream accepts the word

Behaviour:
- Reset (async, active-high): Out_Valid=0, Out_Data=0, Out_Source=0, round-robin pointer=0. In_Ready is forced to 0 while Reset=1.
- Slot free condition: can_accept = !Out_Valid | Out_Ready.
- Grant, combinational from the current-cycle In_Valid, Mode, Selection and pointer:
  - fixed mode: grant[Selection] = In_Valid[Selection], all other grants 0.
  - round-robin mode: the first valid channel searching upward from the pointer, wrapping at N-1 to 0.
- In_Ready = grant & {N{can_accept}}. At most one bit is set.
- Transfer on input i: In_Valid[i] & In_Ready[i].
  - On the next edge: Out_Data <= channel i data, Out_Source <= i, Out_Valid <= 1.
  - Latency is exactly 1 cycle from acceptance to Out_Valid.
- Output drain: Out_Valid & Out_Ready with no new transfer, so Out_Valid <= 0. Out_Data and Out_Source hold their last values.
- Drain and accept in the same cycle: the new word replaces the old one and Out_Valid stays 1. Full throughput is 1 word/cycle.
- Stall: while Out_Valid & !Out_Ready, Out_Data and Out_Source are held stable and In_Ready is 0.
- Pointer: updates only on a transfer in round-robin mode, to (granted index + 1) mod N. It is unchanged in fixed mode and on idle cycles.
- In fixed mode, a Selection value >= N (possible when N is not a power of 2) grants nothing.
- Mode or Selection changes take effect on the very next grant evaluation. A word already held in the output register is unaffected.
- Reset asserted mid-transfer: the held word is discarded immediately (async). No transfer is counted in that cycle.
- No combinational path from Out_Ready to Out_Data. Out_Ready reaches In_Ready combinationally, and that path is intended.

Decomposition:
- Package mux_pkg holds:
  - WORD_W = 16
  - typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_t
- Sub-module rr_priority_picker (parameter N) holds the combinational search:
  - inputs: request vector, pointer
  - outputs: one-hot grant, encoded index, any_grant
  - its own unit test is required.
- The top module owns the output register, the pointer register and the handshake.

Test Plan:
1. Reset released, Mode=0, Selection=2, In_Valid=8'h04, In_Data ch2=16'h0003, Out_Ready=1. Required: In_Ready=8'h04; the next cycle shows Out_Valid=1, Out_Data=16'h0003, Out_Source=2.
2. Mode=1, In_Valid=8'hFF held, Out_Ready=1, ch i data = i+1. Required: Out_Source sequence 0,1,2,…,7,0 on consecutive cycles, one word per cycle.
3. Mode=1, In_Valid=8'h81, pointer at 1. Required: grant to ch7 first, then ch0 (wrap), then ch7.
4. Backpressure: Out_Valid=1 holding 16'h00AA, Out_Ready=0 for 3 cycles, ch1 valid with 16'h00BB. Required: In_Ready=0, Out_Data stays 16'h00AA; the cycle Out_Ready=1 accepts ch1, and Out_Data=16'h00BB the next cycle with Out_Valid held at 1.
5. Reset asserted asynchronously mid-cycle while Out_Valid=1. Required: Out_Valid=0, Out_Data=0 immediately, without waiting for a clock edge; pointer returns to 0, so the first grant after release goes to the lowest valid channel.
6. N=5 instance, Mode=0, Selection=6, In_Valid=5'h1F. Required: In_Ready=0 and Out_Valid stays 0.
